irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  Multi-source interrupt controller; successor to the single-source error IRQ stretcher.
//  Collects N_SRC error/event lines (slave error responses, timeouts, etc.).
//  Each source has its own enable and its own mode: PULSE (stretched, retriggerable) or
//    LATCHED (sticky until SW clear).
//  Provides pending/overflow status to the register file, one aggregated irq_o, and the
//    lowest-index active source ID.
// PARAMETERS
//  IRQ_EN         1'b1  0: block disabled, all outputs tied to 0, no flops.
//  N_SRC          4     number of sources, 1..32.
//  IRQ_HOLD_TIME  1024  PULSE-mode pending duration in aclk cycles, >=1.
//  ID_W           $clog2(N_SRC) or 1 if N_SRC==1 (derived; do not override).
// PORTS
//  aclk       in   1      clock.
//  rstn       in   1      asynchronous active-low reset.
//  err_i      in   N_SRC  event per source; level sampled, every high cycle is one event.
//  enable_i   in   N_SRC  per-source enable (from regfile).
//  mode_i     in   N_SRC  per-source mode: 0 = PULSE, 1 = LATCHED.
//  clr_i      in   N_SRC  W1C strobe, one cycle per bit; clears pending and ovf.
//  pending_o  out  N_SRC  per-source pending status (registered).
//  ovf_o      out  N_SRC  per-source overflow: an event arrived while already pending.
//  irq_o      out  1      |(pending_o & enable_i).
//  irq_id_o   out  ID_W   lowest index i with pending_o[i] & enable_i[i]; 0 if none.
// BEHAVIOUR
//  Reset: pending_o, ovf_o and all counters go to 0, so irq_o = 0 and irq_id_o = 0.
//  Event definition: ev[i] = err_i[i] & enable_i[i]. A disabled source records nothing.
//  Latency: ev at edge k -> pending_o[i] = 1 after edge k -> irq_o high in the same cycle
//    (1 cycle from err_i).
//  irq_o / irq_id_o: combinational from the pending flops and enable_i only.
//    Dropping enable_i masks irq_o immediately but does not clear pending.
//  LATCHED (mode_i[i]=1):
//    - ev sets pending.
//    - clr sets pending=0 and ovf=0.
//    - ev and clr in the same cycle: clear is applied first, then ev -> pending=1, ovf=0.
//  PULSE (mode_i[i]=0), per-source down-counter cnt[i] of width $clog2(IRQ_HOLD_TIME+1):
//    - ev: pending=1, cnt=IRQ_HOLD_TIME-1 (retrigger reloads the counter).
//    - no ev, pending=1, cnt!=0: cnt decrements.
//    - no ev, pending=1, cnt==0: pending=0.
//    - One single-cycle ev gives pending high for exactly IRQ_HOLD_TIME cycles.
//    - clr without ev: pending=0, cnt=0, ovf=0. clr together with ev: ev wins (reload), ovf=0.
//  Overflow: ev while pending already 1 and no clr in that cycle -> ovf=1.
//    ovf is sticky in both modes until clr.
//  Counter width: no wrap. cnt never decrements below 0 and never loads above IRQ_HOLD_TIME-1.
//  Mode change mid-operation:
//    - mode_i is sampled every cycle.
//    - PULSE->LATCHED with pending=1: pending holds until clr; cnt frozen.
//    - LATCHED->PULSE with pending=1: countdown resumes from the held cnt.
//      cnt is 0 after a latched-only set, so pending drops on the next edge unless ev.
//  Simultaneous events on several sources: all are recorded in the same cycle.
//    irq_id_o picks the lowest index.
//  Reset asserted mid-hold: everything returns to 0 asynchronously.
//    No event is generated on reset release.
// TESTING
//  1. PULSE, HOLD=8: err_i[0] high for 1 cycle, enable=1 -> pending_o[0] and irq_o high
//     for exactly 8 cycles, starting 1 cycle after err_i; ovf_o[0]=0.
//  2. PULSE retrigger: events at cycles 0 and 5, HOLD=8 -> pending high cycles 1..13,
//     ovf_o[0]=1 from cycle 6.
//  3. LATCHED: err_i[2] pulse -> pending_o[2] stays 1 for 100+ cycles; clr_i[2] -> 0 next
//     cycle. clr+err in same cycle -> pending stays 1, ovf_o[2]=0.
//  4. Masking: enable_i[1]=0 with err_i[1] pulse -> no pending. Pending source 3 then
//     enable_i[3]->0 -> irq_o drops same cycle, pending_o[3] stays 1.
//  5. Priority/simultaneous: err_i=4'b1010 at once -> pending_o=4'b1010, irq_id_o=1.
//     clr_i[1] -> irq_id_o=3.
//  6. rstn asserted mid-hold (cnt=4) -> all outputs 0 immediately, no irq after release.
//     IRQ_EN=0 build: irq_o constant 0 under any stimulus.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Status/event bundle between the register file (master) and the interrupt controller (slave).
// ID_W is derived from N_SRC here so both ends always agree on the source-ID width.
interface irq_ctrl_if #(
  parameter int N_SRC = 4
);
  localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] err_i;
  logic [N_SRC-1:0] enable_i;
  logic [N_SRC-1:0] mode_i;
  logic [N_SRC-1:0] clr_i;
  logic [N_SRC-1:0] pending_o;
  logic [N_SRC-1:0] ovf_o;
  logic             irq_o;
  logic [ID_W-1:0]  irq_id_o;

  modport master (
    output err_i, enable_i, mode_i, clr_i,
    input  pending_o, ovf_o, irq_o, irq_id_o
  );

  modport slave (
    input  err_i, enable_i, mode_i, clr_i,
    output pending_o, ovf_o, irq_o, irq_id_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: per-source PULSE (stretched, retriggerable) or LATCHED
// pending state, sticky overflow, aggregated irq and lowest-index active source ID.
module irq_ctrl #(
  parameter logic IRQ_EN        = 1'b1,
  parameter int   N_SRC         = 4,
  parameter int   IRQ_HOLD_TIME = 1024
) (
  input logic       aclk,
  input logic       rstn,
  irq_ctrl_if.slave bus
);
  localparam int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = $clog2(IRQ_HOLD_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IRQ_HOLD_TIME - 1);

  generate
    if (IRQ_EN) begin : g_en
      logic [N_SRC-1:0] pend_q, pend_d;
      logic [N_SRC-1:0] ovf_q, ovf_d;
      logic [CNT_W-1:0] cnt_q [N_SRC];
      logic [CNT_W-1:0] cnt_d [N_SRC];
      logic [N_SRC-1:0] ev;
      logic [N_SRC-1:0] act;
      logic [ID_W-1:0]  id;

      assign ev = bus.err_i & bus.enable_i;

      always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < N_SRC; i++) begin
          if (bus.clr_i[i]) begin
            ovf_d[i] = 1'b0;
          end else if (ev[i] && pend_q[i]) begin
            ovf_d[i] = 1'b1;
          end

          if (bus.mode_i[i]) begin
            // Latched: clear first, then a same-cycle event re-sets; the counter stays frozen.
            if (bus.clr_i[i]) begin
              pend_d[i] = 1'b0;
              cnt_d[i]  = '0;
            end
            if (ev[i]) begin
              pend_d[i] = 1'b1;
            end
          end else begin
            if (ev[i]) begin
              pend_d[i] = 1'b1;
              cnt_d[i]  = CNT_LOAD;
            end else if (bus.clr_i[i]) begin
              pend_d[i] = 1'b0;
              cnt_d[i]  = '0;
            end else if (pend_q[i]) begin
              if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
              end else begin
                pend_d[i] = 1'b0;
              end
            end
          end
        end
      end

      always_ff @(posedge aclk or negedge rstn) begin
        if (!rstn) begin
          pend_q <= '0;
          ovf_q  <= '0;
          for (int i = 0; i < N_SRC; i++) begin
            cnt_q[i] <= '0;
          end
        end else begin
          pend_q <= pend_d;
          ovf_q  <= ovf_d;
          for (int i = 0; i < N_SRC; i++) begin
            cnt_q[i] <= cnt_d[i];
          end
        end
      end

      assign act = pend_q & bus.enable_i;

      // Scan from the top down so the lowest active index is the last one written.
      always_comb begin
        id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
          if (act[i]) begin
            id = ID_W'(i);
          end
        end
      end

      assign bus.pending_o = pend_q;
      assign bus.ovf_o     = ovf_q;
      assign bus.irq_o     = |act;
      assign bus.irq_id_o  = id;
    end else begin : g_dis
      assign bus.pending_o = '0;
      assign bus.ovf_o     = '0;
      assign bus.irq_o     = 1'b0;
      assign bus.irq_id_o  = '0;
    end
  endgenerate
endmodule
